cam_rgb565_capture: RTL and testbench

- Front-end capture stage between the camera parallel bus and the image-processing pipeline.
- Samples 8-bit camera bytes qualified by i_hsync (line-active) and i_vsync (vertical blanking, active-high).
- Pairs the bytes into RGB565 pixels and expands them to 3x8-bit RGB.
- Emits a one-cycle pixel strobe with x/y coordinates and start-of-frame, end-of-line and frame-done markers; discards partial frames after reset.

---
 rtl/img_pkg.sv | 17 +
 rtl/cam_rgb565_capture_if.sv | 31 +++
 rtl/rgb565_expand.sv | 33 +++
 rtl/cam_rgb565_capture.sv | 179 +++++++++++++++++
 tb/tb_cam_rgb565_capture.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/img_pkg.sv
// Shared image-pipeline types: RGB pixel payload, capture FSM states, channel indices.
package img_pkg;

  typedef logic [2:0][7:0] rgb_t;

  typedef enum logic [1:0] {
    S_SYNC   = 2'd0,
    S_VBLANK = 2'd1,
    S_HI     = 2'd2,
    S_LO     = 2'd3
  } cap_state_e;

  localparam logic [1:0] CH_R = 2'd2;
  localparam logic [1:0] CH_G = 2'd1;
  localparam logic [1:0] CH_B = 2'd0;

endpackage

// File: rtl/cam_rgb565_capture_if.sv
// Camera byte bus in, expanded pixel stream out.
// master = camera/sink side of the bench or system, slave = capture block.
interface cam_rgb565_capture_if #(
  parameter int unsigned X_W = 10,
  parameter int unsigned Y_W = 9
);
  import img_pkg::*;

  logic [7:0]     i_data;
  logic           i_hsync;
  logic           i_vsync;
  logic           o_valid;
  rgb_t           o_rgb;
  logic [X_W-1:0] o_x;
  logic [Y_W-1:0] o_y;
  logic           o_sof;
  logic           o_eol;
  logic           o_frame_done;
  logic           o_frame_err;

  modport master (
    output i_data, i_hsync, i_vsync,
    input  o_valid, o_rgb, o_x, o_y, o_sof, o_eol, o_frame_done, o_frame_err
  );

  modport slave (
    input  i_data, i_hsync, i_vsync,
    output o_valid, o_rgb, o_x, o_y, o_sof, o_eol, o_frame_done, o_frame_err
  );

endinterface

// File: rtl/rgb565_expand.sv
// Combinational RGB565 (hi/lo byte pair) to 3x8-bit RGB expansion.
// CAM_CAPTURE_EXPAND_EN defined: MSB replication into the low bits; undefined: zero padding.
module rgb565_expand
  import img_pkg::*;
(
  input  logic [7:0] hi_i,
  input  logic [7:0] lo_i,
  output rgb_t       rgb_c_o
);

  logic [4:0] r5;
  logic [5:0] g6;
  logic [4:0] b5;

  assign r5 = hi_i[7:3];
  assign g6 = {hi_i[2:0], lo_i[7:5]};
  assign b5 = lo_i[4:0];

  // Widen each channel to 8 bits.
  always_comb begin
    rgb_c_o = '0;
`ifdef CAM_CAPTURE_EXPAND_EN
    rgb_c_o[CH_R] = {r5, r5[4:2]};
    rgb_c_o[CH_G] = {g6, g6[5:4]};
    rgb_c_o[CH_B] = {b5, b5[4:2]};
`else
    rgb_c_o[CH_R] = {r5, 3'b000};
    rgb_c_o[CH_G] = {g6, 2'b00};
    rgb_c_o[CH_B] = {b5, 3'b000};
`endif
  end

endmodule

// File: rtl/cam_rgb565_capture.sv
// Camera parallel-bus capture: pairs bytes into RGB565 pixels, expands to RGB888,
// tracks x/y and emits frame markers. Partial frames after reset are discarded.
// Expansion style selected by CAM_CAPTURE_EXPAND_EN (see rgb565_expand).
module cam_rgb565_capture
  import img_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned IMG_HEIGHT = 480,
  parameter int unsigned X_W        = 10,
  parameter int unsigned Y_W        = 9
) (
  input  logic                i_clk,
  input  logic                i_reset,
  cam_rgb565_capture_if.slave cam_bus
);

  // One extra bit so the counters can sit at the saturation limit.
  localparam int unsigned     XC_W  = X_W + 1;
  localparam int unsigned     YC_W  = Y_W + 1;
  localparam logic [XC_W-1:0] X_LIM = XC_W'(IMG_WIDTH);
  localparam logic [YC_W-1:0] Y_LIM = YC_W'(IMG_HEIGHT);

  cap_state_e      state_q, state_d;
  logic            hsync_q;
  logic [7:0]      hi_q, hi_d;
  logic [XC_W-1:0] x_q, x_d;
  logic [YC_W-1:0] y_q, y_d;
  logic            got_byte_q, got_byte_d;
  logic            valid_q, valid_d;
  rgb_t            rgb_q, rgb_d;
  logic [X_W-1:0]  ox_q, ox_d;
  logic [Y_W-1:0]  oy_q, oy_d;
  logic            sof_q, sof_d;
  logic            eol_q, eol_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            line_end_c;
  logic            emit_ok_c;
  rgb_t            pix_c;

  rgb565_expand u_expand (
    .hi_i    (hi_q),
    .lo_i    (cam_bus.i_data),
    .rgb_c_o (pix_c)
  );

  assign emit_ok_c = (x_q < X_LIM) && (y_q < Y_LIM);

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= S_SYNC;
    else         state_q <= state_d;
  end

  // Next state: vsync always wins inside a frame.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_SYNC:   if (cam_bus.i_vsync)  state_d = S_VBLANK;
      S_VBLANK: if (!cam_bus.i_vsync) state_d = S_HI;
      S_HI: begin
        if (cam_bus.i_vsync)      state_d = S_VBLANK;
        else if (cam_bus.i_hsync) state_d = S_LO;
      end
      S_LO: begin
        if (cam_bus.i_vsync) state_d = S_VBLANK;
        else                 state_d = S_HI;
      end
      default: state_d = S_SYNC;
    endcase
  end

  // Datapath and output next values.
  always_comb begin
    hi_d       = hi_q;
    x_d        = x_q;
    y_d        = y_q;
    got_byte_d = got_byte_q;
    valid_d    = 1'b0;
    rgb_d      = rgb_q;
    ox_d       = ox_q;
    oy_d       = oy_q;
    sof_d      = 1'b0;
    eol_d      = 1'b0;
    done_d     = 1'b0;
    err_d      = err_q;
    line_end_c = 1'b0;
    case (state_q)
      S_VBLANK: begin
        if (!cam_bus.i_vsync) begin
          x_d        = '0;
          y_d        = '0;
          got_byte_d = 1'b0;
          err_d      = 1'b0;
        end
      end
      S_HI: begin
        if (cam_bus.i_vsync) begin
          done_d = 1'b1;
        end else if (cam_bus.i_hsync) begin
          hi_d       = cam_bus.i_data;
          got_byte_d = 1'b1;
        end else if (hsync_q) begin
          line_end_c = 1'b1;
        end
      end
      S_LO: begin
        if (cam_bus.i_vsync) begin
          done_d = 1'b1;
        end else if (cam_bus.i_hsync) begin
          if (emit_ok_c) begin
            valid_d = 1'b1;
            rgb_d   = pix_c;
            ox_d    = X_W'(x_q);
            oy_d    = Y_W'(y_q);
            sof_d   = (x_q == '0) && (y_q == '0);
            x_d     = x_q + XC_W'(1);
          end else begin
            err_d = 1'b1;
          end
        end else begin
          // Odd byte count: the lone high byte is dropped.
          err_d      = 1'b1;
          line_end_c = 1'b1;
        end
      end
      default: ;
    endcase
    if (line_end_c) begin
      eol_d      = 1'b1;
      x_d        = '0;
      got_byte_d = 1'b0;
      if (got_byte_q && (y_q < Y_LIM)) y_d = y_q + YC_W'(1);
    end
  end

  // Datapath and output registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      hsync_q    <= 1'b0;
      hi_q       <= '0;
      x_q        <= '0;
      y_q        <= '0;
      got_byte_q <= 1'b0;
      valid_q    <= 1'b0;
      rgb_q      <= '0;
      ox_q       <= '0;
      oy_q       <= '0;
      sof_q      <= 1'b0;
      eol_q      <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      hsync_q    <= cam_bus.i_hsync;
      hi_q       <= hi_d;
      x_q        <= x_d;
      y_q        <= y_d;
      got_byte_q <= got_byte_d;
      valid_q    <= valid_d;
      rgb_q      <= rgb_d;
      ox_q       <= ox_d;
      oy_q       <= oy_d;
      sof_q      <= sof_d;
      eol_q      <= eol_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign cam_bus.o_valid      = valid_q;
  assign cam_bus.o_rgb        = rgb_q;
  assign cam_bus.o_x          = ox_q;
  assign cam_bus.o_y          = oy_q;
  assign cam_bus.o_sof        = sof_q;
  assign cam_bus.o_eol        = eol_q;
  assign cam_bus.o_frame_done = done_q;
  assign cam_bus.o_frame_err  = err_q;

endmodule

// File: tb/tb_cam_rgb565_capture.sv
// Bench for cam_rgb565_capture: a full-size instance (640x480) and a tiny one (4x2)
// share the same camera stimulus; a line-level reference model predicts pixels,
// line/frame markers and the error flag for each.
module tb_cam_rgb565_capture;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    int          x;
    int          y;
    logic [23:0] rgb;
    bit          sof;
  } px_t;

`ifdef CAM_CAPTURE_EXPAND_EN
  localparam logic [31:0] EXP_GREEN = 32'h0000FF00;
  localparam logic [31:0] EXP_AAAB  = 32'h00AD555A;
`else
  localparam logic [31:0] EXP_GREEN = 32'h0000FC00;
  localparam logic [31:0] EXP_AAAB  = 32'h00A85458;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data;
  logic       hsync;
  logic       vsync;

  int n_vec;
  int n_miscmp;

  // Reference model state, index 0 = full-size DUT, 1 = tiny DUT.
  int  W[2];
  int  H[2];
  int  my[2];
  bit  merr[2];
  bit  armed[2];
  int  eol_exp[2];
  int  done_exp[2];
  int  eol_seen[2];
  int  done_seen[2];
  px_t qa[$];
  px_t qb[$];
  px_t pa;
  px_t pb;

  cam_rgb565_capture_if #(.X_W(10), .Y_W(9)) if_a ();
  cam_rgb565_capture_if #(.X_W(2),  .Y_W(1)) if_b ();

  assign if_a.i_data  = data;
  assign if_a.i_hsync = hsync;
  assign if_a.i_vsync = vsync;
  assign if_b.i_data  = data;
  assign if_b.i_hsync = hsync;
  assign if_b.i_vsync = vsync;

  cam_rgb565_capture #(.IMG_WIDTH(640), .IMG_HEIGHT(480), .X_W(10), .Y_W(9)) dut_a (
    .i_clk   (clk),
    .i_reset (rst),
    .cam_bus (if_a)
  );

  cam_rgb565_capture #(.IMG_WIDTH(4), .IMG_HEIGHT(2), .X_W(2), .Y_W(1)) dut_b (
    .i_clk   (clk),
    .i_reset (rst),
    .cam_bus (if_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miscmp++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected RGB888 from a byte pair, straight from the channel bit layout.
  function automatic logic [23:0] exp_rgb(input logic [7:0] hi, input logic [7:0] lo);
    int r5, g6, b5, r8, g8, b8;
    r5 = int'(hi) / 8;
    g6 = (int'(hi) % 8) * 8 + int'(lo) / 32;
    b5 = int'(lo) % 32;
`ifdef CAM_CAPTURE_EXPAND_EN
    r8 = r5 * 8 + r5 / 4;
    g8 = g6 * 4 + g6 / 16;
    b8 = b5 * 8 + b5 / 4;
`else
    r8 = r5 * 8;
    g8 = g6 * 4;
    b8 = b5 * 8;
`endif
    return 24'(r8 * 65536 + g8 * 256 + b8);
  endfunction

  function automatic bq_t rb(input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  // Drive a line's bytes; optionally end it with an hsync fall and a short gap.
  task automatic send_bytes(input bq_t b, input bit end_line);
    bit  e[2];
    px_t p;
    for (int i = 0; i < b.size(); i++) begin
      data  = b[i];
      hsync = 1'b1;
      for (int d = 0; d < 2; d++) begin
        e[d] = 1'b0;
        if (armed[d] && (i % 2 == 1)) begin
          if ((i / 2) < W[d] && my[d] < H[d]) begin
            p.x   = i / 2;
            p.y   = my[d];
            p.rgb = exp_rgb(b[i-1], b[i]);
            p.sof = (i / 2 == 0) && (my[d] == 0);
            if (d == 0) qa.push_back(p);
            else        qb.push_back(p);
            e[d] = 1'b1;
          end else begin
            merr[d] = 1'b1;
          end
        end
      end
      tick();
      chk("valid_a", 32'(if_a.o_valid), 32'(e[0]));
      chk("valid_b", 32'(if_b.o_valid), 32'(e[1]));
    end
    if (end_line && b.size() > 0) begin
      hsync = 1'b0;
      data  = 8'($urandom);
      for (int d = 0; d < 2; d++) begin
        e[d] = armed[d];
        if (armed[d]) begin
          if (b.size() % 2 == 1) merr[d] = 1'b1;
          eol_exp[d]++;
          if (my[d] < H[d]) my[d]++;
        end
      end
      tick();
      chk("eol_a", 32'(if_a.o_eol), 32'(e[0]));
      chk("eol_b", 32'(if_b.o_eol), 32'(e[1]));
      repeat ($urandom_range(1, 3)) tick();
    end
  endtask

  task automatic check_err();
    chk("err_a", 32'(if_a.o_frame_err), 32'(merr[0]));
    chk("err_b", 32'(if_b.o_frame_err), 32'(merr[1]));
  endtask

  // Vertical blanking pulse; hs=1 keeps hsync high on the rising edge (mid-line abort).
  task automatic pulse(input bit hs);
    bit was[2];
    vsync = 1'b1;
    hsync = hs;
    data  = 8'($urandom);
    for (int d = 0; d < 2; d++) begin
      was[d] = armed[d];
      if (armed[d]) done_exp[d]++;
    end
    tick();
    chk("done_a", 32'(if_a.o_frame_done), 32'(was[0]));
    chk("done_b", 32'(if_b.o_frame_done), 32'(was[1]));
    chk("eol_at_vs_a", 32'(if_a.o_eol), 32'd0);
    chk("eol_at_vs_b", 32'(if_b.o_eol), 32'd0);
    hsync = 1'b0;
    repeat (3) tick();
    vsync = 1'b0;
    tick();
    tick();
    for (int d = 0; d < 2; d++) begin
      armed[d] = 1'b1;
      my[d]    = 0;
      merr[d]  = 1'b0;
    end
    chk("err_clr_a", 32'(if_a.o_frame_err), 32'd0);
    chk("err_clr_b", 32'(if_b.o_frame_err), 32'd0);
    chk("pend_a", 32'(qa.size()), 32'd0);
    chk("pend_b", 32'(qb.size()), 32'd0);
    chk("eol_cnt_a", 32'(eol_seen[0]), 32'(eol_exp[0]));
    chk("eol_cnt_b", 32'(eol_seen[1]), 32'(eol_exp[1]));
    chk("done_cnt_a", 32'(done_seen[0]), 32'(done_exp[0]));
    chk("done_cnt_b", 32'(done_seen[1]), 32'(done_exp[1]));
  endtask

  task automatic chk_zero();
    chk("rst_valid_a", 32'(if_a.o_valid), 32'd0);
    chk("rst_rgb_a", 32'(if_a.o_rgb), 32'd0);
    chk("rst_x_a", 32'(if_a.o_x), 32'd0);
    chk("rst_y_a", 32'(if_a.o_y), 32'd0);
    chk("rst_sof_a", 32'(if_a.o_sof), 32'd0);
    chk("rst_eol_a", 32'(if_a.o_eol), 32'd0);
    chk("rst_done_a", 32'(if_a.o_frame_done), 32'd0);
    chk("rst_err_a", 32'(if_a.o_frame_err), 32'd0);
    chk("rst_valid_b", 32'(if_b.o_valid), 32'd0);
    chk("rst_rgb_b", 32'(if_b.o_rgb), 32'd0);
    chk("rst_err_b", 32'(if_b.o_frame_err), 32'd0);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) tick();
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      armed[d] = 1'b0;
      my[d]    = 0;
      merr[d]  = 1'b0;
    end
    chk_zero();
  endtask

  // Output monitor: every strobe must match the next predicted pixel.
  always @(negedge clk) begin
    if (if_a.o_valid === 1'b1) begin
      if (qa.size() == 0) begin
        chk("pix_unexp_a", 32'(if_a.o_valid), 32'd0);
      end else begin
        pa = qa.pop_front();
        chk("pix_x_a", 32'(if_a.o_x), 32'(pa.x));
        chk("pix_y_a", 32'(if_a.o_y), 32'(pa.y));
        chk("pix_rgb_a", 32'(if_a.o_rgb), 32'(pa.rgb));
        chk("pix_sof_a", 32'(if_a.o_sof), 32'(pa.sof));
      end
    end
    if (if_b.o_valid === 1'b1) begin
      if (qb.size() == 0) begin
        chk("pix_unexp_b", 32'(if_b.o_valid), 32'd0);
      end else begin
        pb = qb.pop_front();
        chk("pix_x_b", 32'(if_b.o_x), 32'(pb.x));
        chk("pix_y_b", 32'(if_b.o_y), 32'(pb.y));
        chk("pix_rgb_b", 32'(if_b.o_rgb), 32'(pb.rgb));
        chk("pix_sof_b", 32'(if_b.o_sof), 32'(pb.sof));
      end
    end
    if (if_a.o_eol === 1'b1)        eol_seen[0]++;
    if (if_b.o_eol === 1'b1)        eol_seen[1]++;
    if (if_a.o_frame_done === 1'b1) done_seen[0]++;
    if (if_b.o_frame_done === 1'b1) done_seen[1]++;
  end

  initial begin
    bq_t b;
    int  nl;
    int  n;
    bit  aborted;
    n_vec    = 0;
    n_miscmp = 0;
    data     = 8'h00;
    hsync    = 1'b0;
    vsync    = 1'b0;
    rst      = 1'b1;
    W[0] = 640; H[0] = 480;
    W[1] = 4;   H[1] = 2;
    for (int d = 0; d < 2; d++) begin
      my[d] = 0; merr[d] = 1'b0; armed[d] = 1'b0;
      eol_exp[d] = 0; done_exp[d] = 0; eol_seen[d] = 0; done_seen[d] = 0;
    end

    do_reset(3);

    // Bytes before the first vsync are ignored.
    send_bytes(rb(6), 1'b1);
    send_bytes(rb(4), 1'b1);
    check_err();
    pulse(1'b0);

    // Pure red then pure green, then the 0xAA/0xAB pair.
    b = '{8'hF8, 8'h00, 8'h07, 8'hE0};
    send_bytes(b, 1'b1);
    chk("tp_green", 32'(if_a.o_rgb), EXP_GREEN);
    b = '{8'hAA, 8'hAB};
    send_bytes(b, 1'b1);
    chk("tp_aaab", 32'(if_a.o_rgb), EXP_AAAB);
    check_err();
    pulse(1'b0);

    // Three 10-byte lines: tiny instance clips in x and y.
    repeat (3) send_bytes(rb(10), 1'b1);
    check_err();
    pulse(1'b0);

    // Odd line, then the next line starts at x=0, y=1.
    send_bytes(rb(3), 1'b1);
    send_bytes(rb(4), 1'b1);
    chk("odd_next_x", 32'(if_a.o_x), 32'd1);
    chk("odd_next_y", 32'(if_a.o_y), 32'd1);
    check_err();
    pulse(1'b0);

    // vsync rises after byte 5 of a line.
    send_bytes(rb(5), 1'b0);
    check_err();
    pulse(1'b1);
    send_bytes(rb(2), 1'b1);
    chk("post_abort_x", 32'(if_a.o_x), 32'd0);
    chk("post_abort_y", 32'(if_a.o_y), 32'd0);
    check_err();
    pulse(1'b0);

    // Reset mid-line; capture resumes only after a full vsync pulse.
    send_bytes(rb(3), 1'b0);
    do_reset(1);
    send_bytes(rb(3), 1'b1);
    send_bytes(rb(4), 1'b1);
    check_err();
    pulse(1'b0);
    send_bytes(rb(4), 1'b1);
    check_err();
    pulse(1'b0);

    // Random frames, occasionally aborted mid-line.
    for (int f = 0; f < 20; f++) begin
      nl      = int'($urandom_range(1, 4));
      aborted = 1'b0;
      for (int l = 0; l < nl; l++) begin
        n = int'($urandom_range(1, 12));
        if (l == nl - 1 && $urandom_range(0, 3) == 0) begin
          send_bytes(rb(n), 1'b0);
          check_err();
          pulse(1'b1);
          aborted = 1'b1;
        end else begin
          send_bytes(rb(n), 1'b1);
        end
      end
      if (!aborted) begin
        check_err();
        pulse(1'b0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
